// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//
// Board-side front end for the alarm-clock push-button PIO. Each raw, bouncing
// KEY pin is synchronized into clk_clk, then debounced by a small per-channel
// FSM. The accepted level drives the PIO input; one-cycle press/release strobes
// serve local logic such as alarm snooze.
//
// Optional feature, enabled by defining BUTTON_AUTOREPEAT_EN:
//   a held button re-issues btn_press after HOLD_CYCLES clocks, then every
//   REPEAT_CYCLES clocks while it stays down. Without the macro the hold
//   counter is not built and exactly one btn_press is emitted per press.
//
// Channels are fully independent; every flop clears asynchronously on
// reset_reset.
// -----------------------------------------------------------------------------
module button_conditioner #(
    parameter int NUM_BTN         = 2,
    parameter int ACTIVE_LOW      = 1,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HOLD_CYCLES     = 25000000,
    parameter int REPEAT_CYCLES   = 10000000
) (
    input  logic               clk_clk,
    input  logic               reset_reset,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release
);

    // -------------------------------------------------------------------------
    // Elaboration-time parameter guards
    // -------------------------------------------------------------------------
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("button_conditioner: SYNC_STAGES must be in 2..4");
    end
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("button_conditioner: DEBOUNCE_CYCLES must be >= 2");
    end
    if (HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_repeat
        $error("button_conditioner: HOLD_CYCLES and REPEAT_CYCLES must be >= 1");
    end

    // -------------------------------------------------------------------------
    // Shared constants and types
    // -------------------------------------------------------------------------
    // Pin value of a released button; the synchronizer resets to this so that
    // reset never looks like a press on its own.
    localparam logic RELEASED = (ACTIVE_LOW != 0);

    // Debounce counter: wide enough to hold DEBOUNCE_CYCLES.
    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

`ifdef BUTTON_AUTOREPEAT_EN
    // Hold counter: shared between the initial hold and the repeat period.
    localparam int            HOLD_MAX  = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES
                                                                         : REPEAT_CYCLES;
    localparam int            HW        = $clog2(HOLD_MAX + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_CYCLES - 1);
`endif

    // Debounce states. PEND_* states are waiting for the new level to stay
    // stable for DEBOUNCE_CYCLES clocks before it is accepted.
    typedef enum logic [1:0] {
        ST_UP      = 2'd0,
        ST_PEND_DN = 2'd1,
        ST_DOWN    = 2'd2,
        ST_PEND_UP = 2'd3
    } state_t;

    // -------------------------------------------------------------------------
    // Per-channel synchronizer + debounce FSM
    // -------------------------------------------------------------------------
    for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan

        logic [SYNC_STAGES-1:0] sync_q;
        logic                   s;          // synchronized sample, 1 = pressed

        state_t        state_q, state_d;
        logic [CW-1:0] cnt_q,   cnt_d;
        logic          level_q, level_d;
        logic          press_q, press_d;
        logic          release_q, release_d;

`ifdef BUTTON_AUTOREPEAT_EN
        logic [HW-1:0] hold_q, hold_d;
        logic          rep_q,  rep_d;      // 0 = waiting out HOLD, 1 = repeating
        logic [HW-1:0] hold_last;
`endif

        // Shift the raw pin through SYNC_STAGES flops to tame metastability.
        always_ff @(posedge clk_clk or posedge reset_reset) begin
            // NOTE: sequential state is updated with non-blocking assignments so
            // every stage samples the previous value of its neighbour.
            if (reset_reset) begin
                sync_q <= {SYNC_STAGES{RELEASED}};
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw[i]};
            end
        end

        assign s = sync_q[SYNC_STAGES-1] ^ RELEASED;

`ifdef BUTTON_AUTOREPEAT_EN
        assign hold_last = rep_q ? REP_LAST : HOLD_LAST;
`endif

        // State register: FSM state, debounce counter and registered outputs.
        always_ff @(posedge clk_clk or posedge reset_reset) begin
            if (reset_reset) begin
                state_q   <= ST_UP;
                cnt_q     <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
`ifdef BUTTON_AUTOREPEAT_EN
                hold_q    <= '0;
                rep_q     <= 1'b0;
`endif
            end else begin
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                level_q   <= level_d;
                press_q   <= press_d;
                release_q <= release_d;
`ifdef BUTTON_AUTOREPEAT_EN
                hold_q    <= hold_d;
                rep_q     <= rep_d;
`endif
            end
        end

        // Next-state logic: accept a level only after it has been stable for
        // DEBOUNCE_CYCLES consecutive samples; any bounce restarts the wait.
        always_comb begin
            // NOTE: every variable gets a default here so no path leaves one
            // unassigned, which would otherwise infer a latch.
            state_d   = state_q;
            cnt_d     = cnt_q;
            level_d   = level_q;
            press_d   = 1'b0;
            release_d = 1'b0;
`ifdef BUTTON_AUTOREPEAT_EN
            hold_d    = hold_q;
            rep_d     = rep_q;
`endif

            unique case (state_q)
                ST_UP: begin
                    if (s) begin
                        state_d = ST_PEND_DN;
                        cnt_d   = CNT_ONE;
                    end
                end

                ST_PEND_DN: begin
                    if (!s) begin
                        // Glitch: drop back without any strobe.
                        state_d = ST_UP;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = ST_DOWN;
                        cnt_d   = '0;
                        level_d = 1'b1;
                        press_d = 1'b1;
`ifdef BUTTON_AUTOREPEAT_EN
                        // Hold time is measured from this press strobe.
                        hold_d  = '0;
                        rep_d   = 1'b0;
`endif
                    end else begin
                        // Transition fires at CNT_LAST, so the count never
                        // passes it and cannot wrap.
                        cnt_d   = cnt_q + CNT_ONE;
                    end
                end

                ST_DOWN: begin
                    if (!s) begin
                        // Hold counter is simply left alone: frozen while the
                        // release is being qualified.
                        state_d = ST_PEND_UP;
                        cnt_d   = CNT_ONE;
                    end
`ifdef BUTTON_AUTOREPEAT_EN
                    else if (hold_q == hold_last) begin
                        // Auto-repeat strobe; level is already 1.
                        press_d = 1'b1;
                        hold_d  = '0;
                        rep_d   = 1'b1;
                    end else begin
                        hold_d  = hold_q + HW'(1);
                    end
`endif
                end

                ST_PEND_UP: begin
                    if (s) begin
                        // Bounce while releasing: back to DOWN, hold resumes.
                        state_d = ST_DOWN;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d   = ST_UP;
                        cnt_d     = '0;
                        level_d   = 1'b0;
                        release_d = 1'b1;
`ifdef BUTTON_AUTOREPEAT_EN
                        hold_d    = '0;
                        rep_d     = 1'b0;
`endif
                    end else begin
                        cnt_d     = cnt_q + CNT_ONE;
                    end
                end

                default: begin
                    state_d = ST_UP;
                    cnt_d   = '0;
                end
            endcase
        end

        assign btn_level[i]   = level_q;
        assign btn_press[i]   = press_q;
        assign btn_release[i] = release_q;
    end

endmodule

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
//
// Directed stimulus for button_conditioner with DEBOUNCE_CYCLES = 4 and
// SYNC_STAGES = 2, so an accepted change appears 6 clocks after the raw pin
// moves. Stimulus pushes the strobe it expects (cycle, press, release, level)
// into a queue; an independent monitor pops and compares whenever the DUT
// raises any strobe. Build with BUTTON_AUTOREPEAT_EN to also cover auto-repeat
// (HOLD_CYCLES = 10, REPEAT_CYCLES = 5).
// -----------------------------------------------------------------------------
module tb_button_conditioner;

    localparam int NUM_BTN  = 2;
    localparam int DEB      = 4;
    localparam int SYNC     = 2;
    localparam int LAT      = SYNC + DEB;   // raw pin to strobe, in clocks

    logic               clk_clk;
    logic               reset_reset;
    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_press;
    logic [NUM_BTN-1:0] btn_release;

    button_conditioner #(
        .NUM_BTN         (NUM_BTN),
        .ACTIVE_LOW      (1),
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DEB),
        .HOLD_CYCLES     (10),
        .REPEAT_CYCLES   (5)
    ) dut (
        .clk_clk     (clk_clk),
        .reset_reset (reset_reset),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release)
    );

    // 100 MHz-style bench clock; period is irrelevant to the design.
    initial clk_clk = 1'b0;
    always #5 clk_clk = ~clk_clk;

    // Posedge counter used to time-stamp expected and observed strobes.
    int cyc = 0;
    always @(posedge clk_clk) cyc <= cyc + 1;

    typedef struct {
        int                 at;
        logic [NUM_BTN-1:0] press;
        logic [NUM_BTN-1:0] rel;
        logic [NUM_BTN-1:0] level;
    } evt_t;

    evt_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    task automatic push_evt(input int at, input logic [NUM_BTN-1:0] press,
                            input logic [NUM_BTN-1:0] rel,
                            input logic [NUM_BTN-1:0] level);
        evt_t e;
        e.at = at; e.press = press; e.rel = rel; e.level = level;
        exp_q.push_back(e);
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk_clk);
    endtask

    // Monitor: sample on the falling edge, away from the active edge.
    logic [NUM_BTN-1:0] prev_level = '0;
    evt_t               got;
    always @(negedge clk_clk) begin
        if (reset_reset) begin
            prev_level = btn_level;
        end else begin
            while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_strobe: strobe absent, required at cycle %0d (now %0d)",
                         exp_q[0].at, cyc);
                void'(exp_q.pop_front());
            end
            if (btn_press != '0 || btn_release != '0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: press=%b release=%b at cycle %0d, required none",
                             btn_press, btn_release, cyc);
                end else begin
                    got = exp_q.pop_front();
                    check("strobe_cycle",  cyc,         got.at);
                    check("strobe_press",  btn_press,   got.press);
                    check("strobe_release", btn_release, got.rel);
                    check("strobe_level",  btn_level,   got.level);
                end
            end
            check("level_moves_only_with_strobe",
                  (btn_level ^ prev_level) & ~(btn_press | btn_release), 0);
            check("press_release_exclusive", btn_press & btn_release, 0);
            prev_level = btn_level;
        end
    end

    // Hard time limit so a stuck run still terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, bench did not finish");
        $fatal(1, "watchdog");
    end

    int p;
    initial begin
        reset_reset = 1'b1;
        btn_raw     = 2'b11;

        // Reset values with both pins released.
        wait_neg(3);
        check("reset_level",   btn_level,   2'b00);
        check("reset_press",   btn_press,   2'b00);
        check("reset_release", btn_release, 2'b00);
        reset_reset = 1'b0;
        wait_neg(20);
        check("idle_level", btn_level, 2'b00);

        // Clean press on button 0.
        btn_raw = 2'b10;
        push_evt(cyc + LAT, 2'b01, 2'b00, 2'b01);
        wait_neg(10);
        check("clean_press_level", btn_level, 2'b01);

        // Clean release.
        btn_raw = 2'b11;
        push_evt(cyc + LAT, 2'b00, 2'b01, 2'b00);
        wait_neg(10);

        // Bounce: low 3, high 1, then low; strobe timed from the last fall.
        btn_raw = 2'b10;
        wait_neg(3);
        btn_raw = 2'b11;
        wait_neg(1);
        btn_raw = 2'b10;
        push_evt(cyc + LAT, 2'b01, 2'b00, 2'b01);
        wait_neg(10);
        check("bounce_press_level", btn_level, 2'b01);
        btn_raw = 2'b11;
        push_evt(cyc + LAT, 2'b00, 2'b01, 2'b00);
        wait_neg(10);

        // Isolated 3-cycle glitch: rejected, no strobe at all.
        btn_raw = 2'b10;
        wait_neg(3);
        btn_raw = 2'b11;
        wait_neg(15);
        check("glitch_level", btn_level, 2'b00);

        // Both buttons in the same cycle, then release button 1 only.
        btn_raw = 2'b00;
        push_evt(cyc + LAT, 2'b11, 2'b00, 2'b11);
        wait_neg(LAT);
        btn_raw = 2'b10;
        push_evt(cyc + LAT, 2'b00, 2'b10, 2'b01);
        wait_neg(LAT);
        check("partial_release_level", btn_level, 2'b01);
        btn_raw = 2'b11;
        push_evt(cyc + LAT, 2'b00, 2'b01, 2'b00);
        wait_neg(10);

        // Long hold on button 0: repeats only with the auto-repeat build.
        btn_raw = 2'b10;
        p = cyc + LAT;
        push_evt(p, 2'b01, 2'b00, 2'b01);
`ifdef BUTTON_AUTOREPEAT_EN
        push_evt(p + 10, 2'b01, 2'b00, 2'b01);
        push_evt(p + 15, 2'b01, 2'b00, 2'b01);
        push_evt(p + 20, 2'b01, 2'b00, 2'b01);
        push_evt(p + 25, 2'b01, 2'b00, 2'b01);
        push_evt(p + 30, 2'b01, 2'b00, 2'b01);
`endif
        wait_neg(LAT + 30);
        check("long_hold_level", btn_level, 2'b01);
        btn_raw = 2'b11;
        push_evt(cyc + LAT, 2'b00, 2'b01, 2'b00);
        wait_neg(10);

        // Asynchronous reset mid-cycle while a release is pending.
        btn_raw = 2'b00;
        push_evt(cyc + LAT, 2'b11, 2'b00, 2'b11);
        wait_neg(8);
        check("pre_reset_level", btn_level, 2'b11);
        btn_raw = 2'b11;
        wait_neg(2);
        @(posedge clk_clk);
        #3 reset_reset = 1'b1;
        #1;
        check("async_reset_level",   btn_level,   2'b00);
        check("async_reset_press",   btn_press,   2'b00);
        check("async_reset_release", btn_release, 2'b00);
        wait_neg(3);
        reset_reset = 1'b0;
        wait_neg(20);
        check("post_reset_idle_level", btn_level, 2'b00);

        // Button 0 held through reset release counts as a new press.
        reset_reset = 1'b1;
        btn_raw     = 2'b10;
        wait_neg(3);
        reset_reset = 1'b0;
        push_evt(cyc + LAT, 2'b01, 2'b00, 2'b01);
        wait_neg(8);
        check("held_through_reset_level", btn_level, 2'b01);
        btn_raw = 2'b11;
        push_evt(cyc + LAT, 2'b00, 2'b01, 2'b00);
        wait_neg(12);

        // Anything still queued never appeared.
        while (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL missing_strobe: strobe absent, required at cycle %0d",
                     exp_q[0].at);
            void'(exp_q.pop_front());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
